// File: rtl/ls_arb_pkg.sv
// Shared types and constants for the local-store arbiter and its refill sequencer.
package ls_arb_pkg;

  localparam int QW_BITS = 128;
  localparam int QW_OFF  = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DMA,
    OWN_LS,
    OWN_RF
  } owner_e;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_FILL,
    RF_DRAIN
  } rf_state_e;

endpackage

// File: rtl/ls_refill_seq.sv
// Icache line-refill sequencer: FSM, issue counter, beat ordering and starvation counter.
// Define LS_ARB_CWF_EN to issue the line critical-word-first instead of from quadword 0.
module ls_refill_seq
  import ls_arb_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int LINE_QW    = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rf_req,
  input  logic [ADDR_W-1:0]                rf_addr,
  input  logic                             rf_abort,
  input  logic                             rf_gnt,
  output logic                             rf_want,
  output logic [ADDR_W-QW_OFF-1:0]         rf_qaddr,
  output logic                             starving,
  output logic                             in_drain,
  output logic [$clog2(LINE_QW)-1:0]       ret_beat
);

  localparam int BEAT_W = $clog2(LINE_QW);
  localparam int LINE_W = ADDR_W - QW_OFF - BEAT_W;
  localparam int STV_W  = $clog2(STARVE_MAX + 1);
  localparam logic [STV_W-1:0]  STV_LIMIT = STV_W'(STARVE_MAX);
  localparam logic [BEAT_W-1:0] LAST_ISSUE = BEAT_W'(LINE_QW - 1);

  rf_state_e          state;
  logic [LINE_W-1:0]  line_q;
  logic [BEAT_W-1:0]  start_q;
  logic [BEAT_W-1:0]  issue_cnt;
  logic [BEAT_W-1:0]  cur_beat;
  logic [STV_W-1:0]   starve_cnt;
  logic               unused_low_addr;

  // Beat index wraps naturally within the line because it is exactly BEAT_W bits wide.
  assign cur_beat        = start_q + issue_cnt;
  assign rf_qaddr        = {line_q, cur_beat};
  assign rf_want         = (state == RF_FILL) && !rf_abort;
  assign starving        = (starve_cnt == STV_LIMIT);
  assign in_drain        = (state == RF_DRAIN);
  assign unused_low_addr = ^rf_addr[QW_OFF+BEAT_W-1:0];

  // NOTE: all state in this clocked block uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RF_IDLE;
      line_q     <= '0;
      start_q    <= '0;
      issue_cnt  <= '0;
      starve_cnt <= '0;
      ret_beat   <= '0;
    end else if (rf_abort) begin
      state      <= RF_IDLE;
      issue_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        RF_IDLE: begin
          starve_cnt <= '0;
          if (rf_req) begin
            state     <= RF_FILL;
            line_q    <= rf_addr[ADDR_W-1 -: LINE_W];
            issue_cnt <= '0;
`ifdef LS_ARB_CWF_EN
            start_q   <= rf_addr[QW_OFF +: BEAT_W];
`else
            start_q   <= '0;
`endif
          end
        end
        RF_FILL: begin
          if (rf_gnt) begin
            starve_cnt <= '0;
            issue_cnt  <= issue_cnt + 1'b1;
            ret_beat   <= cur_beat;
            if (issue_cnt == LAST_ISSUE) state <= RF_DRAIN;
          end else if (!starving) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        RF_DRAIN: begin
          // The last read was issued one cycle ago, so its data returns now.
          state      <= RF_IDLE;
          starve_cnt <= '0;
        end
        default: state <= RF_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ls_arbiter.sv
// Single-port local-store arbiter for DMA, LSU and icache refill, with a refill sequencer.
// Define LS_ARB_CWF_EN to enable critical-word-first line refill.
module ls_arbiter
  import ls_arb_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int LINE_QW    = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        dma_req,
  input  logic                        dma_we,
  input  logic [ADDR_W-1:0]           dma_addr,
  input  logic [QW_BITS-1:0]          dma_wdata,
  output logic                        dma_gnt,
  output logic                        dma_rvalid,
  output logic [QW_BITS-1:0]          dma_rdata,
  input  logic                        ls_req,
  input  logic                        ls_we,
  input  logic [ADDR_W-1:0]           ls_addr,
  input  logic [QW_BITS-1:0]          ls_wdata,
  output logic                        ls_gnt,
  output logic                        ls_rvalid,
  output logic [QW_BITS-1:0]          ls_rdata,
  input  logic                        rf_req,
  input  logic [ADDR_W-1:0]           rf_addr,
  input  logic                        rf_abort,
  output logic                        rf_valid,
  output logic [$clog2(LINE_QW)-1:0]  rf_beat,
  output logic [QW_BITS-1:0]          rf_data,
  output logic                        rf_done,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-QW_OFF-1:0]    mem_addr,
  output logic [QW_BITS-1:0]          mem_wdata,
  input  logic [QW_BITS-1:0]          mem_rdata
);

  logic                        rf_want;
  logic                        rf_gnt;
  logic                        starving;
  logic                        in_drain;
  logic [ADDR_W-QW_OFF-1:0]    rf_qaddr;
  logic [$clog2(LINE_QW)-1:0]  ret_beat;
  owner_e                      owner_d;
  owner_e                      owner_q;
  logic                        unused_low_addr;

  assign unused_low_addr = ^{dma_addr[QW_OFF-1:0], ls_addr[QW_OFF-1:0]};

  ls_refill_seq #(
    .ADDR_W     (ADDR_W),
    .LINE_QW    (LINE_QW),
    .STARVE_MAX (STARVE_MAX)
  ) u_refill_seq (
    .clk      (clk),
    .reset    (reset),
    .rf_req   (rf_req),
    .rf_addr  (rf_addr),
    .rf_abort (rf_abort),
    .rf_gnt   (rf_gnt),
    .rf_want  (rf_want),
    .rf_qaddr (rf_qaddr),
    .starving (starving),
    .in_drain (in_drain),
    .ret_beat (ret_beat)
  );

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    dma_gnt   = 1'b0;
    ls_gnt    = 1'b0;
    rf_gnt    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_NONE;
    if (!reset) begin
      if (rf_want && starving) rf_gnt  = 1'b1;
      else if (dma_req)        dma_gnt = 1'b1;
      else if (ls_req)         ls_gnt  = 1'b1;
      else if (rf_want)        rf_gnt  = 1'b1;
    end
    if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr[ADDR_W-1:QW_OFF];
      mem_wdata = dma_wdata;
      owner_d   = dma_we ? OWN_NONE : OWN_DMA;
    end else if (ls_gnt) begin
      mem_we    = ls_we;
      mem_addr  = ls_addr[ADDR_W-1:QW_OFF];
      mem_wdata = ls_wdata;
      owner_d   = ls_we ? OWN_NONE : OWN_LS;
    end else if (rf_gnt) begin
      mem_addr  = rf_qaddr;
      owner_d   = OWN_RF;
    end
    mem_en = dma_gnt | ls_gnt | rf_gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) owner_q <= OWN_NONE;
    else       owner_q <= owner_d;
  end

  // An abort in the return cycle drops the refill beat; reset drops any return.
  assign dma_rvalid = !reset && (owner_q == OWN_DMA);
  assign ls_rvalid  = !reset && (owner_q == OWN_LS);
  assign rf_valid   = !reset && (owner_q == OWN_RF) && !rf_abort;
  assign rf_done    = rf_valid && in_drain;
  assign rf_beat    = rf_valid ? ret_beat : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;
  assign ls_rdata   = ls_rvalid  ? mem_rdata : '0;
  assign rf_data    = rf_valid   ? mem_rdata : '0;

endmodule

// File: doc/ls_arbiter.md
Name: ls_arbiter

Overview:
Single-port local-store arbiter and instruction-refill sequencer. Shares one quadword-wide local-store port between three requesters: DMA engine, load/store unit (LSU) and the icache line-refill path. On an icache miss it runs the multi-beat line fill, including abort on branch mispredict. Sits between the icache/LSU/DMA and the local-store SRAM macro.

Parameters:
ADDR_W, 18, byte-address width (256 KB local store)
LINE_QW, 4, quadwords per icache line (64 B line)
STARVE_MAX, 8, consecutive denied cycles before refill is forced to win

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
dma_req  input  1  DMA access request, single beat
dma_we  input  1  DMA write (1) / read (0)
dma_addr  input  ADDR_W  DMA byte address; low 4 bits ignored
dma_wdata  input  128  DMA write data
dma_gnt  output  1  DMA granted this cycle
dma_rvalid  output  1  DMA read data valid
dma_rdata  output  128  DMA read data
ls_req, ls_we, ls_addr, ls_wdata  input  1/1/ADDR_W/128  LSU request, same meaning as DMA
ls_gnt, ls_rvalid  output  1  LSU grant / read valid
ls_rdata  output  128  LSU read data
rf_req  input  1  icache miss refill request, level, held until rf_done
rf_addr  input  ADDR_W  missing instruction byte address
rf_abort  input  1  cancel refill (mispredict redirect)
rf_valid  output  1  refill beat valid
rf_beat  output  $clog2(LINE_QW)  quadword index within line of current beat
rf_data  output  128  refill beat data
rf_done  output  1  pulse with final rf_valid of a line
mem_en, mem_we  output  1  SRAM enable / write enable
mem_addr  output  ADDR_W-4  SRAM quadword index
mem_wdata  output  128  SRAM write data
mem_rdata  input  128  SRAM read data, 1-cycle latency after mem_en

Behaviour:
- Reset: all gnt/rvalid/rf_valid/rf_done/mem_en/mem_we = 0; data outputs 0; FSM IDLE; starve counter 0; owner tag NONE.
- Grants combinational, same cycle as request; granted access drives mem_* same cycle; at most one grant per cycle; mem_en = OR of grants.
- Priority: if starve == STARVE_MAX and refill has a beat to issue -> refill; else DMA > LSU > refill.
- Reads: owner tag registered on grant; next cycle the owner's rvalid (or rf_valid) = 1, its rdata = mem_rdata. Writes produce no rvalid. Back-to-back grants each cycle allowed.
- Refill FSM: IDLE -> FILL when rf_req=1: latch base = rf_addr with low log2(LINE_QW*16) bits cleared; issue count 0. FILL: refill requests port each cycle; on grant read base+order(issue), issue++. After final issue -> DRAIN. DRAIN: final beat returns with rf_valid=1, rf_done=1 -> IDLE. Next rf_req acceptable the cycle after rf_done.
- Beat order without optional feature: 0,1,...,LINE_QW-1; rf_beat = index of returning quadword.
- Starve counter: +1 each FILL cycle refill is denied, saturates at STARVE_MAX; cleared on refill grant and in IDLE.
- rf_abort (any state): FSM -> IDLE next cycle, counter cleared; a refill read already issued returns with rf_valid suppressed; rf_done not raised. rf_abort wins over simultaneous rf_req; request re-sampled next cycle.
- rf_req changes while in FILL/DRAIN ignored.
- Reset mid-burst: all state cleared, no pending rvalid emitted.

Optional Feature:
LS_ARB_CWF_EN: critical-word-first. Defined: beat order starts at quadword containing rf_addr and wraps modulo LINE_QW (e.g. qw 2 of 4 -> 2,3,0,1); rf_done still on the LINE_QW-th beat. Undefined: sequential order from 0.

Decomposition:
- Package ls_arb_pkg: owner enum (OWN_NONE, OWN_DMA, OWN_LS, OWN_RF), refill state enum (RF_IDLE, RF_FILL, RF_DRAIN), QW_BITS=128, QW_OFF=4.
- Sub-module ls_refill_seq: refill FSM, issue counter, beat ordering, starve counter; outputs refill request, mem quadword address and starving flag to the top-level priority mux.

Test Plan:
- Reset, then LSU write addr 0x100 data 0xA5.., LSU read 0x100 -> ls_gnt same cycle, ls_rvalid next cycle, ls_rdata=0xA5..; mem_addr=0x10.
- rf_req addr 0x1234, no contention -> reads qw 0x120..0x123 on consecutive cycles, rf_beat 0..3, rf_done with beat 3, 5 cycles request-to-done.
- DMA and LSU continuously requesting during refill -> DMA always granted, LSU and refill starve; after 8 denied cycles refill granted one beat, counter cleared; repeats until line complete.
- rf_abort one cycle after 2nd refill issue -> that beat's rf_valid suppressed, no rf_done, FSM IDLE; new rf_req 0x2000 starts a clean fill from qw 0x200.
- With LS_ARB_CWF_EN, rf_addr 0x1228 -> beat order 2,3,0,1, rf_done with beat 1.
- Reset asserted mid-burst with read in flight -> no rf_valid/ls_rvalid next cycle, all outputs 0.
